// File: rtl/fetch_stage.sv
// fetch_stage: 16-bit instruction fetch with a one-entry skid buffer, redirects and bubble insertion.
// Define FETCH_PERF_CNT_EN to add the perf_fetched/perf_redirects counters.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] new_pc,
  input  logic        jump,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] pc_out,
  output logic [15:0] ir_out,
  output logic [15:0] IPCP2,
  output logic        if_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_redirects
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, SKID, DISCARD} state_t;
  state_t      state_q;
  logic [15:0] fetch_pc_q, skid_pc_q, skid_ir_q, pc_q, ir_q, ipcp2_q, addr_q;
  logic        req_q, valid_q;
  logic        redirect, load;
  logic [15:0] tgt, pc_inc, ld_pc, ld_ir;
  always_comb begin
    redirect = !jump && valid_q && !stall;
    load     = !stall && !redirect && ((state_q == REQ && imem_valid) || state_q == SKID);
    tgt      = new_pc & 16'hFFFE;
    pc_inc   = fetch_pc_q + 16'd2;
    ld_pc    = state_q == SKID ? skid_pc_q : fetch_pc_q;
    ld_ir    = state_q == SKID ? skid_ir_q : imem_rdata;
  end
  // A redirect with the request still in flight must wait in DISCARD to swallow its response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      skid_pc_q  <= 16'h0000;
      skid_ir_q  <= 16'h0000;
      pc_q       <= 16'h0000;
      ir_q       <= 16'h0000;
      ipcp2_q    <= 16'h0000;
      addr_q     <= 16'h0000;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else if (state_q == IDLE) begin
      state_q <= REQ;
      req_q   <= 1'b1;
      addr_q  <= fetch_pc_q;
    end else if (redirect) begin
      fetch_pc_q <= tgt;
      valid_q    <= 1'b0;
      ir_q       <= 16'h0000;
      skid_pc_q  <= 16'h0000;
      skid_ir_q  <= 16'h0000;
      if (state_q == REQ && !imem_valid) begin
        state_q <= DISCARD;
      end else begin
        state_q <= REQ;
        req_q   <= 1'b1;
        addr_q  <= tgt;
      end
    end else if (load) begin
      pc_q       <= ld_pc;
      ir_q       <= ld_ir;
      ipcp2_q    <= ld_pc + 16'd2;
      valid_q    <= 1'b1;
      fetch_pc_q <= pc_inc;
      req_q      <= 1'b1;
      addr_q     <= pc_inc;
      state_q    <= REQ;
    end else if (state_q == REQ && imem_valid) begin
      skid_pc_q <= fetch_pc_q;
      skid_ir_q <= imem_rdata;
      req_q     <= 1'b0;
      state_q   <= SKID;
    end else if (state_q == REQ && !stall) begin
      valid_q <= 1'b0;
    end else if (state_q == DISCARD && imem_valid) begin
      state_q <= REQ;
      addr_q  <= fetch_pc_q;
    end
  end
  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign pc_out    = pc_q;
  assign ir_out    = ir_q;
  assign IPCP2     = ipcp2_q;
  assign if_valid  = valid_q;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetched_q, redirects_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_q   <= 16'h0000;
      redirects_q <= 16'h0000;
    end else begin
      fetched_q   <= fetched_q + {15'd0, load};
      redirects_q <= redirects_q + {15'd0, redirect};
    end
  end
  assign perf_fetched   = fetched_q;
  assign perf_redirects = redirects_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random and directed stimulus against a program-order PC model with a scoreboard.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] new_pc = 16'h0000;
  logic        jump = 1'b1;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_valid = 1'b0;
  logic [15:0] pc_out, ir_out, IPCP2;
  logic        if_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched, perf_redirects;
`endif

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .new_pc(new_pc), .jump(jump), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .pc_out(pc_out), .ir_out(ir_out), .IPCP2(IPCP2), .if_valid(if_valid)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_redirects(perf_redirects)
`endif
  );

  always #5 clk = ~clk;

  int          total = 0, bad = 0, consumed = 0, since = 0, redirects = 0;
  int          lat_min = 1, lat_max = 1, age = 0, lat = 1;
  logic [15:0] mem [0:65535];
  logic [15:0] exp_q [$];
  logic [15:0] model_pc = 16'h0000;
  logic [15:0] e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Memory: the response arrives in the lat-th cycle the request is visible (1 = same cycle).
  always @(negedge clk) begin
    if (!imem_req) begin
      age = 0;
      imem_valid = 1'b0;
    end else begin
      if (imem_valid || age == 0) begin
        age = 0;
        lat = $urandom_range(lat_max, lat_min);
      end
      age++;
      imem_valid = (age == lat);
      imem_rdata = imem_valid ? mem[imem_addr] : 16'($urandom);
    end
  end

  // Program-order model: a consumed instruction is followed by pc+2, or by the target if jump=0.
  task automatic drive(input logic s, input logic j, input logic [15:0] np);
    stall = s;
    jump = j;
    new_pc = np;
    if (if_valid && !s) begin
      if (!j) redirects++;
      model_pc = j ? 16'(model_pc + 16'd2) : (np & 16'hFFFE);
      exp_q.push_back(model_pc);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (reset) begin
      since = 0;
    end else if (if_valid && !stall) begin
      since = 0;
      consumed++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_instr: pc_out=%h delivered with nothing expected", pc_out);
      end else begin
        e = exp_q.pop_front();
        chk("pc_out", {16'd0, pc_out}, {16'd0, e});
        chk("ir_out", {16'd0, ir_out}, {16'd0, mem[e]});
        chk("IPCP2", {16'd0, IPCP2}, {16'd0, 16'(e + 16'd2)});
      end
    end else begin
      since++;
      if (since >= 100) begin
        total++;
        bad++;
        $display("FAIL timeout: no instruction delivered for %0d cycles", since);
        since = 0;
      end
    end
  end

  task automatic do_reset;
    @(negedge clk);
    #2 reset = 1'b1;
    stall = 1'b0;
    jump = 1'b1;
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_ir_out", ir_out, 0);
    chk("rst_IPCP2", IPCP2, 0);
    chk("rst_if_valid", if_valid, 0);
    exp_q.delete();
    model_pc = 16'h0000;
    exp_q.push_back(model_pc);
    redirects = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(output logic hit);
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      hit = if_valid;
      drive(1'b0, 1'b1, 16'h0000);
    end
  endtask

  initial begin
    logic [15:0] p, i, a_hold, last_addr;
    logic        hit;
    int          nv, nchg, c0;
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    mem[0] = 16'h1D60;
    mem[2] = 16'h1961;

    do_reset;
    nv = 0;
    repeat (8) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 16'h0000);
      #1 nv += int'(if_valid);
    end
    chk("lat1_valid_cycles", nv, 7);

    do_reset;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      hit = if_valid && pc_out == 16'h0004;
      drive(1'b0, !hit, 16'h0041);
    end
    chk("reach_pc4", hit, 1);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h0000);
    #1 chk("redir_bubble_valid", if_valid, 0);
    chk("redir_bubble_ir", ir_out, 0);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h0000);
    #1 chk("redir_target_pc", pc_out, 16'h0040);
    chk("redir_target_ipcp2", IPCP2, 16'h0042);

    @(negedge clk);
    chk("pre_wrap_valid", if_valid, 1);
    drive(1'b0, 1'b0, 16'hFFFE);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h0000);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h0000);
    #1 chk("wrap_pc", pc_out, 16'hFFFE);
    chk("wrap_ipcp2", IPCP2, 16'h0000);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h0000);
    #1 chk("wrap_next_pc", pc_out, 16'h0000);

    @(negedge clk);
    p = pc_out;
    i = ir_out;
    drive(1'b1, 1'b1, 16'h0000);
    repeat (3) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 16'h0300);
      #1 chk("stall_req_low", imem_req, 0);
      chk("stall_hold_pc", pc_out, p);
      chk("stall_hold_ir", ir_out, i);
      chk("stall_hold_valid", if_valid, 1);
    end
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h0000);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h0000);
    #1 chk("skid_release_pc", pc_out, 16'(p + 16'd2));
    chk("skid_release_valid", if_valid, 1);

    lat_min = 3;
    lat_max = 3;
    do_reset;
    nv = 0;
    nchg = 0;
    last_addr = 16'h0000;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 16'h0000);
      #1 nv += int'(if_valid);
      if (k > 0 && imem_addr != last_addr) nchg++;
      last_addr = imem_addr;
    end
    chk("lat3_valid_cycles", nv, 3);
    chk("lat3_addr_changes", nchg, 3);

    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      @(negedge clk);
      hit = if_valid;
      a_hold = imem_addr;
      drive(1'b0, !hit, 16'h0100);
    end
    chk("reach_valid_lat3", hit, 1);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h0000);
    #1 chk("discard_addr_hold", imem_addr, a_hold);
    chk("discard_req_hold", imem_req, 1);
    wait_valid(hit);
    chk("discard_next_pc", pc_out, 16'h0100);
    chk("discard_next_ir", ir_out, mem[16'h0100]);

    do_reset;
    wait_valid(hit);
    chk("refetch_pc", pc_out, 16'h0000);
    chk("refetch_ir", ir_out, 16'h1D60);

    lat_min = 1;
    lat_max = 4;
    do_reset;
    c0 = consumed;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset;
      @(negedge clk);
      drive(($urandom % 10) < 3, ($urandom % 8) != 0, 16'($urandom));
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 16'h0000);
    chk("random_progress", (consumed - c0) > 200, 1);
`ifdef FETCH_PERF_CNT_EN
    #1 chk("perf_redirects", perf_redirects, 16'(redirects));
`endif
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
